// File: rtl/pipelined_adder_tree_if.sv
// Handshake bundle for pipelined_adder_tree: upstream operand vector and downstream sum.
// The master modport is the side that drives operands and OUT_READY.
interface pipelined_adder_tree_if #(
  parameter int WIDTH        = 2,
  parameter int NUM_OPERANDS = 8
);
  localparam int LEVELS = $clog2(NUM_OPERANDS);

  logic                          IN_VALID;
  logic                          IN_READY;
  logic [NUM_OPERANDS*WIDTH-1:0] OPERANDS;
  logic                          OUT_VALID;
  logic                          OUT_READY;
  logic [WIDTH+LEVELS-1:0]       SUM;

  modport master (
    output IN_VALID, OPERANDS, OUT_READY,
    input  IN_READY, OUT_VALID, SUM
  );

  modport slave (
    input  IN_VALID, OPERANDS, OUT_READY,
    output IN_READY, OUT_VALID, SUM
  );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined unsigned multi-operand adder: binary tree with one register level per tree level,
// lossless widths and a valid/ready handshake with bubble-collapsing back-pressure.
module pipelined_adder_tree #(
  parameter int WIDTH        = 2,
  parameter int NUM_OPERANDS = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  pipelined_adder_tree_if.slave bus
);
  localparam int LEVELS = $clog2(NUM_OPERANDS);

  generate
    if ((WIDTH < 1) || (NUM_OPERANDS < 2) ||
        ((NUM_OPERANDS & (NUM_OPERANDS - 1)) != 0)) begin : g_param_check
      $error("pipelined_adder_tree: WIDTH must be >=1 and NUM_OPERANDS a power of two >=2");
    end
  endgenerate

  logic [LEVELS-1:0] v_q;
  logic [LEVELS-1:0] v_d;
  logic [LEVELS-1:0] adv;

  // A stage may advance when it, or any stage downstream of it, is empty or the sink is ready.
  always_comb begin : advance_chain
    logic room;
    room = bus.OUT_READY;
    adv  = '0;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      room                 = room | ~v_q[LEVELS-1-k];
      adv[LEVELS-1-k]      = room;
    end
  end

  always_comb begin
    v_d    = v_q;
    v_d[0] = adv[0] ? bus.IN_VALID : v_q[0];
    for (int unsigned i = 1; i < LEVELS; i++) begin
      if (adv[i]) v_d[i] = v_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) v_q <= '0;
    else        v_q <= v_d;
  end

  assign bus.IN_READY  = adv[0];
  assign bus.OUT_VALID = v_q[LEVELS-1];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NL = NUM_OPERANDS >> (l + 1);
    localparam int WL = WIDTH + l + 1;

    logic [WL-1:0] s_q [NL];
    logic [WL-1:0] s_d [NL];

    if (l == 0) begin : g_leaf
      always_comb begin
        for (int unsigned j = 0; j < NL; j++) begin
          s_d[j] = WL'(bus.OPERANDS[(2*j)*WIDTH +: WIDTH]) +
                   WL'(bus.OPERANDS[(2*j+1)*WIDTH +: WIDTH]);
        end
      end
    end else begin : g_node
      always_comb begin
        for (int unsigned j = 0; j < NL; j++) begin
          s_d[j] = WL'(g_lvl[l-1].s_q[2*j]) + WL'(g_lvl[l-1].s_q[2*j+1]);
        end
      end
    end

    // Data loads whenever the stage advances; the valid bit alone marks it meaningful.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int unsigned j = 0; j < NL; j++) s_q[j] <= '0;
      end else if (adv[l]) begin
        for (int unsigned j = 0; j < NL; j++) s_q[j] <= s_d[j];
      end
    end

    if (l == LEVELS - 1) begin : g_root
      assign bus.SUM = s_q[0];
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench: default 8x2-bit tree against a queue scoreboard and occupancy model,
// plus a 2-operand instance checked for legacy 2-bit adder equivalence.
module tb_pipelined_adder_tree;
  logic CLK;
  logic RST_N;

  int unsigned tests;
  int unsigned fails;

  pipelined_adder_tree_if #(.WIDTH(2), .NUM_OPERANDS(8)) bus8 ();
  pipelined_adder_tree_if #(.WIDTH(2), .NUM_OPERANDS(2)) bus2 ();

  pipelined_adder_tree #(.WIDTH(2), .NUM_OPERANDS(8)) dut8 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus8.slave)
  );

  pipelined_adder_tree #(.WIDTH(2), .NUM_OPERANDS(2)) dut2 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus2.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_sum(input logic [15:0] ops);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 8; i++) s += ops[i*2 +: 2];
    return s;
  endfunction

  // Reference model: results in acceptance order; occupancy is the queue length.
  int unsigned exp_q[$];
  logic        held;
  int unsigned held_sum;
  logic        ov_s, acc_s, fire_s;

  task automatic cyc8(input logic iv, input logic [15:0] ops, input logic ordy);
    @(negedge CLK);
    bus8.IN_VALID  = iv;
    bus8.OPERANDS  = ops;
    bus8.OUT_READY = ordy;
    #1;
    check("in_ready", bus8.IN_READY, ((exp_q.size() < 3) || ordy) ? 1 : 0);
    if (held) begin
      check("hold_valid", bus8.OUT_VALID, 1);
      check("hold_sum", bus8.SUM, held_sum);
    end
    ov_s   = bus8.OUT_VALID;
    acc_s  = iv && bus8.IN_READY;
    fire_s = bus8.OUT_VALID && ordy;
    if (fire_s) begin
      check("out_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) check("sum", bus8.SUM, exp_q.pop_front());
    end
    held     = bus8.OUT_VALID && !ordy;
    held_sum = bus8.SUM;
    if (acc_s) exp_q.push_back(ref_sum(ops));
  endtask

  logic [15:0] bp_vec [4];
  int unsigned n_acc;
  int unsigned pa, pb;

  initial begin
    tests = 0;
    fails = 0;
    held  = 1'b0;
    held_sum = 0;
    bp_vec[0] = 16'h0001;
    bp_vec[1] = 16'h0002;
    bp_vec[2] = 16'h0003;
    bp_vec[3] = 16'h0007;

    RST_N = 1'b1;
    bus8.IN_VALID = 1'b0; bus8.OPERANDS = '0; bus8.OUT_READY = 1'b1;
    bus2.IN_VALID = 1'b0; bus2.OPERANDS = '0; bus2.OUT_READY = 1'b1;

    // Asynchronous reset asserted between clock edges
    #12;
    RST_N = 1'b0;
    #1;
    check("rst_out_valid", bus8.OUT_VALID, 0);
    check("rst_sum", bus8.SUM, 0);
    check("rst_in_ready", bus8.IN_READY, 1);
    check("rst_out_valid2", bus2.OUT_VALID, 0);
    check("rst_sum2", bus2.SUM, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single all-max vector: 3-cycle latency, one-cycle result
    cyc8(1'b1, 16'hFFFF, 1'b1);
    check("max_accept", acc_s, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc8(1'b0, 16'h0000, 1'b1);
      check("lat_valid", ov_s, (i == 3) ? 1 : 0);
      if (i == 3) check("max_sum", bus8.SUM, 24);
    end

    // Back-to-back streaming
    for (int i = 0; i < 24; i++) begin
      cyc8((i < 20) ? 1'b1 : 1'b0, 16'($urandom()), 1'b1);
      check("stream_fire", fire_s, (i >= 3 && i < 23) ? 1 : 0);
    end
    check("stream_drained", exp_q.size(), 0);

    // Back-pressure: fill to capacity, then release with simultaneous in/out transfer
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc8(1'b1, bp_vec[n_acc], 1'b0);
      if (acc_s) n_acc++;
    end
    check("bp_accepts", n_acc, 3);
    check("bp_held_sum", bus8.SUM, 1);
    cyc8(1'b1, bp_vec[3], 1'b1);
    check("bp_same_cycle_acc", acc_s, 1);
    check("bp_same_cycle_out", fire_s, 1);
    for (int i = 0; i < 5; i++) cyc8(1'b0, 16'h0000, 1'b1);
    check("bp_drained", exp_q.size(), 0);

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      cyc8(1'($urandom_range(0, 1)), 16'($urandom()), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 6; i++) cyc8(1'b0, 16'h0000, 1'b1);
    check("rand_drained", exp_q.size(), 0);

    // Reset mid-flight discards in-flight vectors
    cyc8(1'b1, 16'h000B, 1'b1);
    cyc8(1'b1, 16'h001F, 1'b1);
    cyc8(1'b0, 16'h0000, 1'b1);
    @(posedge CLK);
    #2;
    check("pre_reset_valid", bus8.OUT_VALID, 1);
    check("pre_reset_sum", bus8.SUM, 5);
    RST_N = 1'b0;
    #1;
    check("midrst_out_valid", bus8.OUT_VALID, 0);
    check("midrst_sum", bus8.SUM, 0);
    check("midrst_in_ready", bus8.IN_READY, 1);
    exp_q.delete();
    held = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc8(1'b0, 16'h0000, 1'b1);
      check("post_rst_idle", ov_s, 0);
    end

    // Two-operand instance: every (A,B) pair, result one cycle after acceptance
    pa = 0;
    pb = 0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge CLK);
      #1;
      if (i > 0) begin
        check("leg_valid", bus2.OUT_VALID, 1);
        check("leg_sum", bus2.SUM, pa + pb);
      end
      check("leg_ready", bus2.IN_READY, 1);
      if (i < 16) begin
        pa = i % 4;
        pb = i / 4;
        bus2.IN_VALID = 1'b1;
        bus2.OPERANDS = 4'(pb * 4 + pa);
      end else begin
        bus2.IN_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    #1;
    check("leg_idle", bus2.OUT_VALID, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
